// File: rtl/mult_arbiter_if.sv
// Handshake bundle shared by multmod and its clients.
// NP ports of X/Y operands packed at [i*N +: N], per-port request/result
// handshake bits, and one shared result bus Z.
// master: drives operands and requests (a client, or the arbiter towards multmod).
// slave : accepts requests and returns results (multmod, or the arbiter towards clients).
interface mult_arbiter_if #(
  parameter int N  = 448,
  parameter int NP = 1
);
  logic [NP*N-1:0] X;
  logic [NP*N-1:0] Y;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   req_busy;
  logic [NP-1:0]   res_valid;
  logic [NP-1:0]   res_ready;
  logic [N-1:0]    Z;

  modport master (
    output X, Y, req_valid, res_ready,
    input  req_ready, req_busy, res_valid, Z
  );

  modport slave (
    input  X, Y, req_valid, res_ready,
    output req_ready, req_busy, res_valid, Z
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares a single multmod between NREQ clients.
// One transaction in flight at a time. Operands are latched at grant, the
// result is presented only to the granted port. Every output is registered.
// Optional macro MULT_ARB_FIXED_PRIO_EN: lowest asserted port index always
// wins and the round-robin pointer is held at 0. Default is round-robin.
module mult_arbiter #(
  parameter int N    = 448,
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mult_arbiter_if.slave            cli,
  mult_arbiter_if.master           mul,
  output logic [$clog2(NREQ)-1:0]  grant
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT, A_RESP} state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [NREQ-1:0]   req_ready_reg, req_ready_next;
  logic [NREQ-1:0]   req_busy_reg, req_busy_next;
  logic [NREQ-1:0]   res_valid_reg, res_valid_next;
  logic [N-1:0]      m_x_reg, m_x_next;
  logic [N-1:0]      m_y_reg, m_y_next;
  logic              m_req_valid_reg, m_req_valid_next;
  logic              m_res_ready_reg, m_res_ready_next;
  logic [N-1:0]      z_reg, z_next;

  // Request vector rotated so that offset 0 is the port rr_ptr points at.
  logic [GW:0]       rot_sum [NREQ];
  logic [GW-1:0]     rot_idx [NREQ];
  logic [NREQ-1:0]   rot_req;
  logic              sel_found;
  logic [GW-1:0]     sel_idx;
  logic [NREQ-1:0]   sel_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot_sum[gi] = {1'b0, rr_ptr_reg} + (GW+1)'(gi);
      assign rot_idx[gi] = (rot_sum[gi] >= (GW+1)'(NREQ)) ?
                           GW'(rot_sum[gi] - (GW+1)'(NREQ)) : GW'(rot_sum[gi]);
      assign rot_req[gi] = cli.req_valid[rot_idx[gi]];
    end
  endgenerate

  // Pick the first requesting port at or after rr_ptr (wrapping).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        sel_found = 1'b1;
        sel_idx   = rot_idx[k];
      end
    end
  end

  assign sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    grant_next       = grant_reg;
    req_ready_next   = '0;
    req_busy_next    = req_busy_reg;
    res_valid_next   = res_valid_reg;
    m_x_next         = m_x_reg;
    m_y_next         = m_y_reg;
    m_req_valid_next = m_req_valid_reg;
    m_res_ready_next = m_res_ready_reg;
    z_next           = z_reg;
    case (state_reg)
      A_IDLE: begin
        if (sel_found) begin
          req_ready_next   = sel_onehot;
          req_busy_next    = sel_onehot;
          m_x_next         = cli.X[int'(sel_idx)*N +: N];
          m_y_next         = cli.Y[int'(sel_idx)*N +: N];
          grant_next       = sel_idx;
          m_req_valid_next = 1'b1;
          m_res_ready_next = 1'b0;
          state_next       = A_ISSUE;
        end
      end
      A_ISSUE: begin
        if (mul.req_ready[0]) begin
          m_req_valid_next = 1'b0;
          state_next       = A_WAIT;
        end
      end
      A_WAIT: begin
        if (!mul.req_busy[0] && mul.res_valid[0]) begin
          z_next                    = mul.Z;
          m_res_ready_next          = 1'b1;
          req_busy_next[grant_reg]  = 1'b0;
          res_valid_next[grant_reg] = 1'b1;
          state_next                = A_RESP;
        end
      end
      A_RESP: begin
        if (cli.res_ready[grant_reg]) begin
          res_valid_next[grant_reg] = 1'b0;
`ifdef MULT_ARB_FIXED_PRIO_EN
          rr_ptr_next = '0;
`else
          rr_ptr_next = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;
`endif
          state_next  = A_IDLE;
        end
      end
      default: state_next = A_IDLE;
    endcase
  end

  // State and registered outputs; async reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= A_IDLE;
      rr_ptr_reg      <= '0;
      grant_reg       <= '0;
      req_ready_reg   <= '0;
      req_busy_reg    <= '0;
      res_valid_reg   <= '0;
      m_x_reg         <= '0;
      m_y_reg         <= '0;
      m_req_valid_reg <= 1'b0;
      m_res_ready_reg <= 1'b0;
      z_reg           <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      grant_reg       <= grant_next;
      req_ready_reg   <= req_ready_next;
      req_busy_reg    <= req_busy_next;
      res_valid_reg   <= res_valid_next;
      m_x_reg         <= m_x_next;
      m_y_reg         <= m_y_next;
      m_req_valid_reg <= m_req_valid_next;
      m_res_ready_reg <= m_res_ready_next;
      z_reg           <= z_next;
    end
  end

  assign cli.req_ready = req_ready_reg;
  assign cli.req_busy  = req_busy_reg;
  assign cli.res_valid = res_valid_reg;
  assign cli.Z         = z_reg;
  assign mul.X         = m_x_reg;
  assign mul.Y         = m_y_reg;
  assign mul.req_valid = m_req_valid_reg;
  assign mul.res_ready = m_res_ready_reg;
  assign grant         = grant_reg;

endmodule
